// File: rtl/single_process_array.sv
// single_process_array: 2x2 "valid" convolution of a 4x4 matrix A with a
// flipped 3x3 kernel B, computed on one shared 8-bit multiply-accumulate
// unit at one product per clock (36 MACs per run). The block is started and
// monitored by a controller through the active_single / done_single handshake.
module single_process_array (
   input  logic       clk,
   input  logic       rst,
   input  logic       active_single,
   input  logic [7:0] a11,
   input  logic [7:0] a12,
   input  logic [7:0] a13,
   input  logic [7:0] a14,
   input  logic [7:0] a21,
   input  logic [7:0] a22,
   input  logic [7:0] a23,
   input  logic [7:0] a24,
   input  logic [7:0] a31,
   input  logic [7:0] a32,
   input  logic [7:0] a33,
   input  logic [7:0] a34,
   input  logic [7:0] a41,
   input  logic [7:0] a42,
   input  logic [7:0] a43,
   input  logic [7:0] a44,
   input  logic [7:0] b11,
   input  logic [7:0] b12,
   input  logic [7:0] b13,
   input  logic [7:0] b21,
   input  logic [7:0] b22,
   input  logic [7:0] b23,
   input  logic [7:0] b31,
   input  logic [7:0] b32,
   input  logic [7:0] b33,
   output logic       done_single,
   output logic [7:0] c11,
   output logic [7:0] c12,
   output logic [7:0] c21,
   output logic [7:0] c22
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Row-major views of the live inputs; only sampled on the snapshot edge.
   logic [7:0] a_in [16];
   logic [7:0] b_in [9];

   // Operands frozen at the start of a run.
   logic [7:0] a_snap [16];
   logic [7:0] b_snap [9];

   // Step counter split as (output index, kernel row, kernel column).
   logic [1:0] out_idx;
   logic [1:0] tap_row;
   logic [1:0] tap_col;
   logic [7:0] acc;

   logic       snap_en;
   logic       mac_en;
   logic       abort_run;
   logic       tap_last;
   logic       last_step;

   logic [1:0] a_row;
   logic [1:0] a_col;
   logic [3:0] a_idx;
   logic [3:0] b_idx;
   logic [7:0] a_sel;
   logic [7:0] b_sel;
   logic [7:0] prod;
   logic [7:0] sum;

   assign a_in[0]  = a11;
   assign a_in[1]  = a12;
   assign a_in[2]  = a13;
   assign a_in[3]  = a14;
   assign a_in[4]  = a21;
   assign a_in[5]  = a22;
   assign a_in[6]  = a23;
   assign a_in[7]  = a24;
   assign a_in[8]  = a31;
   assign a_in[9]  = a32;
   assign a_in[10] = a33;
   assign a_in[11] = a34;
   assign a_in[12] = a41;
   assign a_in[13] = a42;
   assign a_in[14] = a43;
   assign a_in[15] = a44;

   assign b_in[0]  = b11;
   assign b_in[1]  = b12;
   assign b_in[2]  = b13;
   assign b_in[3]  = b21;
   assign b_in[4]  = b22;
   assign b_in[5]  = b23;
   assign b_in[6]  = b31;
   assign b_in[7]  = b32;
   assign b_in[8]  = b33;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: dropping active_single always returns to IDLE.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (active_single) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (!active_single) begin
               state_next = IDLE;
            end else if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (!active_single) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: handshake flag and datapath enables.
   always_comb begin
      done_single = 1'b0;
      snap_en     = 1'b0;
      mac_en      = 1'b0;
      abort_run   = 1'b0;
      unique case (state)
         IDLE: snap_en = active_single;
         RUN: begin
            mac_en    = active_single;
            abort_run = !active_single;
         end
         DONE: done_single = 1'b1;
         default: ;
      endcase
   end

   // Operand selection and the single shared multiply-accumulate.
   // Flipped kernel index (2-row)*3 + (2-col) is folded into 8 - (3*row + col).
   always_comb begin
      a_row     = {1'b0, out_idx[1]} + tap_row;
      a_col     = {1'b0, out_idx[0]} + tap_col;
      a_idx     = {a_row, a_col};
      b_idx     = 4'd8 - (({2'b00, tap_row} * 4'd3) + {2'b00, tap_col});
      a_sel     = a_snap[a_idx];
      b_sel     = b_snap[b_idx];
      prod      = a_sel * b_sel;
      sum       = acc + prod;
      tap_last  = (tap_row == 2'd2) && (tap_col == 2'd2);
      last_step = tap_last && (out_idx == 2'd3);
   end

   // Datapath: snapshot, step counters, accumulator and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_snap  <= '{default: '0};
         b_snap  <= '{default: '0};
         out_idx <= '0;
         tap_row <= '0;
         tap_col <= '0;
         acc     <= '0;
         c11     <= '0;
         c12     <= '0;
         c21     <= '0;
         c22     <= '0;
      end else if (snap_en) begin
         a_snap  <= a_in;
         b_snap  <= b_in;
         out_idx <= '0;
         tap_row <= '0;
         tap_col <= '0;
         acc     <= '0;
      end else if (abort_run) begin
         out_idx <= '0;
         tap_row <= '0;
         tap_col <= '0;
         acc     <= '0;
      end else if (mac_en) begin
         if (tap_last) begin
            acc <= '0;
            unique case (out_idx)
               2'd0: c11 <= sum;
               2'd1: c12 <= sum;
               2'd2: c21 <= sum;
               2'd3: c22 <= sum;
               default: ;
            endcase
         end else begin
            acc <= sum;
         end
         if (tap_col == 2'd2) begin
            tap_col <= '0;
            if (tap_row == 2'd2) begin
               tap_row <= '0;
               out_idx <= out_idx + 2'd1;
            end else begin
               tap_row <= tap_row + 2'd1;
            end
         end else begin
            tap_col <= tap_col + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_single_process_array.sv
// Directed bench for single_process_array: hand-computed convolution results
// and handshake timing for normal, overflow, snapshot, abort and reset cases.
module tb_single_process_array;

   logic       clk;
   logic       rst;
   logic       active_single;
   logic [7:0] a_v [16];
   logic [7:0] b_v [9];
   logic       done_single;
   logic [7:0] c11, c12, c21, c22;

   int unsigned total;
   int unsigned bad;

   single_process_array dut (
      .clk           (clk),
      .rst           (rst),
      .active_single (active_single),
      .a11 (a_v[0]),  .a12 (a_v[1]),  .a13 (a_v[2]),  .a14 (a_v[3]),
      .a21 (a_v[4]),  .a22 (a_v[5]),  .a23 (a_v[6]),  .a24 (a_v[7]),
      .a31 (a_v[8]),  .a32 (a_v[9]),  .a33 (a_v[10]), .a34 (a_v[11]),
      .a41 (a_v[12]), .a42 (a_v[13]), .a43 (a_v[14]), .a44 (a_v[15]),
      .b11 (b_v[0]),  .b12 (b_v[1]),  .b13 (b_v[2]),
      .b21 (b_v[3]),  .b22 (b_v[4]),  .b23 (b_v[5]),
      .b31 (b_v[6]),  .b32 (b_v[7]),  .b33 (b_v[8]),
      .done_single   (done_single),
      .c11 (c11), .c12 (c12), .c21 (c21), .c22 (c22)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic check_c(input string tag, input int e11, input int e12,
                          input int e21, input int e22);
      chk({tag, "_c11"}, 32'(c11), 32'(e11));
      chk({tag, "_c12"}, 32'(c12), 32'(e12));
      chk({tag, "_c21"}, 32'(c21), 32'(e21));
      chk({tag, "_c22"}, 32'(c22), 32'(e22));
   endtask

   task automatic load_a_seq();
      for (int i = 0; i < 16; i++) a_v[i] = 8'(i + 1);
   endtask

   task automatic load_b_seq();
      for (int i = 0; i < 9; i++) b_v[i] = 8'(i + 1);
   endtask

   // active_single high for 37 edges plus `extra`, then low for one edge.
   task automatic do_run(input string tag, input int extra);
      active_single = 1'b1;
      repeat (36) edge1();
      chk({tag, "_pre_done"}, 32'(done_single), 32'd0);
      edge1();
      chk({tag, "_done_rise"}, 32'(done_single), 32'd1);
      for (int k = 0; k < extra; k++) begin
         edge1();
         chk({tag, "_done_hold"}, 32'(done_single), 32'd1);
      end
      active_single = 1'b0;
      edge1();
      chk({tag, "_done_fall"}, 32'(done_single), 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      active_single = 1'b0;
      for (int i = 0; i < 16; i++) a_v[i] = 8'hAA;
      for (int i = 0; i < 9; i++)  b_v[i] = 8'h55;

      // Reset state
      #23;
      check_c("reset", 0, 0, 0, 0);
      chk("reset_done", 32'(done_single), 32'd0);
      rst = 1'b1;
      edge1();

      // Default run: A=1..16, B=1..9
      load_a_seq();
      load_b_seq();
      do_run("default", 0);
      check_c("default", 192, 237, 116, 161);

      // Identity kernel, with done held for two extra edges
      load_a_seq();
      for (int i = 0; i < 9; i++) b_v[i] = 8'd0;
      b_v[4] = 8'd1;
      do_run("ident", 2);
      check_c("ident", 6, 7, 10, 11);

      // Overflow: 9 * 255 * 255 mod 256 = 9
      for (int i = 0; i < 16; i++) a_v[i] = 8'd255;
      for (int i = 0; i < 9; i++)  b_v[i] = 8'd255;
      do_run("ovf", 0);
      check_c("ovf", 9, 9, 9, 9);

      // Inputs zeroed after edge 10; snapshot keeps the default results
      load_a_seq();
      load_b_seq();
      active_single = 1'b1;
      repeat (10) edge1();
      for (int i = 0; i < 16; i++) a_v[i] = 8'd0;
      for (int i = 0; i < 9; i++)  b_v[i] = 8'd0;
      repeat (26) edge1();
      chk("midchg_pre_done", 32'(done_single), 32'd0);
      edge1();
      chk("midchg_done_rise", 32'(done_single), 32'd1);
      active_single = 1'b0;
      edge1();
      chk("midchg_done_fall", 32'(done_single), 32'd0);
      check_c("midchg", 192, 237, 116, 161);

      // Abort: A=0, active dropped so edge 5 sees it low
      for (int i = 0; i < 16; i++) a_v[i] = 8'd0;
      load_b_seq();
      active_single = 1'b1;
      repeat (4) edge1();
      active_single = 1'b0;
      edge1();
      chk("abort_done_e5", 32'(done_single), 32'd0);
      repeat (40) begin
         edge1();
         chk("abort_done_idle", 32'(done_single), 32'd0);
      end
      check_c("abort", 192, 237, 116, 161);

      // Abort after c11 is written: c11 takes the new value, others hold
      for (int i = 0; i < 16; i++) a_v[i] = 8'd0;
      active_single = 1'b1;
      repeat (12) edge1();
      active_single = 1'b0;
      edge1();
      chk("abort2_done", 32'(done_single), 32'd0);
      check_c("abort2", 0, 237, 116, 161);

      // Reset mid-run at edge 20, then a clean full run
      load_a_seq();
      load_b_seq();
      active_single = 1'b1;
      repeat (20) edge1();
      chk("prerst_c11", 32'(c11), 32'd192);
      rst = 1'b0;
      #2;
      check_c("midrst", 0, 0, 0, 0);
      chk("midrst_done", 32'(done_single), 32'd0);
      active_single = 1'b0;
      edge1();
      rst = 1'b1;
      edge1();
      do_run("postrst", 0);
      check_c("postrst", 192, 237, 116, 161);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/single_process_array.md
Name: single_process_array

Overview:
- Computes a 2x2 "valid" 2-D convolution of a 4x4 unsigned 8-bit matrix A with a 3x3 unsigned 8-bit kernel B. The kernel is flipped, giving true convolution rather than correlation.
- Uses one shared multiply-accumulate unit, one product per clock: 36 MACs per run.
- Leaf compute block, started and monitored by a controller through the active_single / done_single handshake.

Parameters:
- none; all widths fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- active_single  input  1  run request; must stay high for the whole run.
- a11..a44  input  8 each (16 ports)  matrix A, row-major; a<r><c> is row r, column c.
- b11..b33  input  8 each (9 ports)  kernel B, row-major.
- done_single  output  1  high while results are complete and valid.
- c11, c12, c21, c22  output  8 each  convolution results, registered.

Behaviour:
- Math: c<r><c> = sum over i,j in 1..3 of a[r+i-1][c+j-1] * b[4-i][4-j], for r,c in 1..2.
  - Products and sum are unsigned.
  - Result is the low 8 bits of the sum (mod 256).
  - Accumulator is 8 bits wide (wrap) or wider, then truncated.
- Reset (rst=0, async):
  - state=IDLE, step counter=0, accumulator=0.
  - c11=c12=c21=c22=0, done_single=0.
- State IDLE:
  - done_single=0.
  - On a posedge with active_single=1: snapshot all 25 A/B inputs into internal registers, clear accumulator and step counter, go to RUN.
  - A/B inputs are ignored everywhere except on this snapshot edge.
- State RUN, steps s=0..35:
  - Output index o=s/9, order c11, c12, c21, c22.
  - Tap t=s%9: i=t/3+1, j=t%3+1.
  - Each posedge with active_single=1: acc += A(snap) element * flipped B(snap) element for (o,t).
  - At t=8: write acc+product to the selected c output and clear acc.
  - After s=35: go to DONE.
- State DONE:
  - done_single=1; c outputs hold.
  - Stays in DONE while active_single=1.
  - On a posedge with active_single=0: go to IDLE; done_single=0 on that edge.
  - A new run requires active_single low for at least one edge first.
- Latency:
  - First edge with active_single=1 is the snapshot; 36 MAC edges follow.
  - done_single rises after the 37th consecutive edge with active_single=1.
  - A controller holding active_single high for exactly 37 edges then dropping it sees a one-cycle done_single pulse.
- Abort: active_single=0 during RUN:
  - Return to IDLE on that edge and discard the partial accumulator.
  - c outputs already written this run keep their new values; the rest keep their previous values.
  - done_single stays 0.
- Reset mid-run: immediate return to reset values.

Test Plan:
- Default run: A=1..16 row-major, B=1..9 row-major, active_single high 37 edges then low.
  - done_single pulses one cycle after edge 37.
  - c11=192, c12=237, c21=116, c22=161.
- Identity kernel: B all 0 except b22=1, A=1..16.
  - c11=6, c12=7, c21=10, c22=11.
- Overflow: all A=255, all B=255.
  - Each output = (9*65025) mod 256 = 9.
- Input change mid-run: change A and B to 0 at edge 10.
  - Results stay 192/237/116/161 because of the snapshot.
- Abort: after a completed default run, rerun with all A=0 and drop active_single at edge 5.
  - done_single never rises; c outputs stay 192/237/116/161.
- Reset: assert rst low at edge 20 of a run.
  - All c outputs =0 and done_single=0 immediately.
  - A following full run gives the correct values.
